// File: rtl/mix_pkg.sv
// Shared fixed-point types, saturation limits and helpers for the IR dry/wet mixer.
package mix_pkg;

    localparam int fxp_size  = 16;
    localparam int frac_size = 12;

    typedef logic signed [fxp_size-1:0]   sample_t;
    typedef logic signed [2*fxp_size-1:0] prod_t;
    typedef logic signed [2*fxp_size:0]   acc_t;
    typedef logic signed [fxp_size:0]     gdiff_t;

    localparam sample_t SAT_MAX = sample_t'((1 << (fxp_size-1)) - 1);
    localparam sample_t SAT_MIN = sample_t'(-(1 << (fxp_size-1)));

    typedef struct packed {
        sample_t data;
        logic    clip;
    } sat_res_t;

    // Arithmetic shift floors toward -inf before the range clamp.
    function automatic sat_res_t sat_shift(acc_t acc);
        acc_t     shifted;
        sat_res_t res;
        shifted = acc >>> frac_size;
        if (shifted > acc_t'(SAT_MAX)) begin
            res.data = SAT_MAX;
            res.clip = 1'b1;
        end else if (shifted < acc_t'(SAT_MIN)) begin
            res.data = SAT_MIN;
            res.clip = 1'b1;
        end else begin
            res.data = shifted[fxp_size-1:0];
            res.clip = 1'b0;
        end
        return res;
    endfunction

    function automatic sample_t ramp_toward(sample_t cur, sample_t tgt, sample_t step);
        gdiff_t  diff;
        sample_t nxt;
        diff = gdiff_t'(tgt) - gdiff_t'(cur);
        if (diff > gdiff_t'(step)) begin
            nxt = cur + step;
        end else if (diff < -gdiff_t'(step)) begin
            nxt = cur - step;
        end else begin
            nxt = tgt;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/mix_align_fifo.sv
// Circular FIFO that holds dry samples until their matching wet sample arrives.
module mix_align_fifo
    import mix_pkg::*;
#(
    parameter  int DEPTH = 8,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push_i,
    input  logic                       pop_i,
    input  logic signed [fxp_size-1:0] wrData_i,
    output logic signed [fxp_size-1:0] rdData_o,
    output logic                       empty_o,
    output logic                       full_o,
    output logic                       drop_o,
    output logic [CNT_W-1:0]           count_o
);

    sample_t          mem [DEPTH];
    logic [PTR_W-1:0] wrPtr_q;
    logic [PTR_W-1:0] rdPtr_q;
    logic [CNT_W-1:0] count_q;
    logic             doPush;
    logic             doPop;

    // A pop frees a slot in the same cycle, so a full FIFO still accepts a push alongside it.
    assign empty_o  = (count_q == '0);
    assign full_o   = (count_q == CNT_W'(DEPTH));
    assign doPop    = pop_i && !empty_o;
    assign doPush   = push_i && (!full_o || doPop);
    assign drop_o   = push_i && !doPush;
    assign rdData_o = mem[rdPtr_q];
    assign count_o  = count_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
        end else begin
            if (doPush) begin
                wrPtr_q <= wrPtr_q + PTR_W'(1);
            end
            if (doPop) begin
                rdPtr_q <= rdPtr_q + PTR_W'(1);
            end
            count_q <= count_q + CNT_W'(doPush) - CNT_W'(doPop);
        end
    end

    always_ff @(posedge clk) begin
        if (doPush) begin
            mem[wrPtr_q] <= wrData_i;
        end
    end

endmodule

// File: rtl/ir_dry_wet_mixer.sv
// Dry/wet mixer behind the IR convolution reverb: o = sat(dry*dry_gain + wet*wet_gain).
// Defining MIX_GAIN_RAMP_EN slews the effective gains toward their targets by ramp_step per wet sample.
module ir_dry_wet_mixer
    import mix_pkg::*;
#(
    parameter int fifo_depth = 8
`ifdef MIX_GAIN_RAMP_EN
    , parameter int ramp_step = 16
`endif
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic signed [fxp_size-1:0] i_dry_data,
    input  logic                       i_dry_valid,
    input  logic signed [fxp_size-1:0] i_wet_data,
    input  logic                       i_wet_valid,
    input  logic signed [fxp_size-1:0] i_dry_gain,
    input  logic signed [fxp_size-1:0] i_wet_gain,
    output logic signed [fxp_size-1:0] o_data,
    output logic                       o_valid,
    output logic                       o_clip,
    output logic                       o_overflow,
    output logic                       o_underflow
);

    localparam int CNT_W = $clog2(fifo_depth) + 1;

    sample_t          fifoRdData;
    logic             fifoEmpty;
    logic             fifoFull;
    logic             fifoDrop;
    logic [CNT_W-1:0] fifoCount;

    sample_t  dryGain_d;
    sample_t  wetGain_d;
    sample_t  dryGain_q;
    sample_t  wetGain_q;
    sample_t  dryOp_q;
    sample_t  wetOp_q;
    logic     s0Valid_q;
    prod_t    dryProd_q;
    prod_t    wetProd_q;
    logic     s1Valid_q;
    acc_t     accSum;
    sat_res_t satRes;
    sample_t  data_q;
    logic     valid_q;
    logic     clip_q;
    logic     overflow_q;
    logic     underflow_q;

    mix_align_fifo #(
        .DEPTH(fifo_depth)
    ) alignFifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (i_dry_valid),
        .pop_i   (i_wet_valid),
        .wrData_i(i_dry_data),
        .rdData_o(fifoRdData),
        .empty_o (fifoEmpty),
        .full_o  (fifoFull),
        .drop_o  (fifoDrop),
        .count_o (fifoCount)
    );

    // The gain registers double as the effective gains; the ramp steps them once per wet sample.
`ifdef MIX_GAIN_RAMP_EN
    assign dryGain_d = ramp_toward(dryGain_q, i_dry_gain, sample_t'(ramp_step));
    assign wetGain_d = ramp_toward(wetGain_q, i_wet_gain, sample_t'(ramp_step));
`else
    assign dryGain_d = i_dry_gain;
    assign wetGain_d = i_wet_gain;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s0Valid_q <= 1'b0;
            dryOp_q   <= '0;
            wetOp_q   <= '0;
            dryGain_q <= '0;
            wetGain_q <= '0;
        end else begin
            s0Valid_q <= i_wet_valid;
            if (i_wet_valid) begin
                dryOp_q   <= fifoEmpty ? '0 : fifoRdData;
                wetOp_q   <= i_wet_data;
                dryGain_q <= dryGain_d;
                wetGain_q <= wetGain_d;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1Valid_q <= 1'b0;
            dryProd_q <= '0;
            wetProd_q <= '0;
        end else begin
            s1Valid_q <= s0Valid_q;
            dryProd_q <= prod_t'(dryOp_q) * prod_t'(dryGain_q);
            wetProd_q <= prod_t'(wetOp_q) * prod_t'(wetGain_q);
        end
    end

    assign accSum = acc_t'(dryProd_q) + acc_t'(wetProd_q);
    assign satRes = sat_shift(accSum);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            data_q  <= '0;
            valid_q <= 1'b0;
            clip_q  <= 1'b0;
        end else begin
            valid_q <= s1Valid_q;
            clip_q  <= s1Valid_q && satRes.clip;
            if (s1Valid_q) begin
                data_q <= satRes.data;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            if (fifoDrop) begin
                overflow_q <= 1'b1;
            end
            if (i_wet_valid && fifoEmpty) begin
                underflow_q <= 1'b1;
            end
        end
    end

    assert property (@(posedge clk) disable iff (!rst)
        !(fifoFull && fifoEmpty) && (fifoCount <= CNT_W'(fifo_depth)));

    assign o_data      = data_q;
    assign o_valid     = valid_q;
    assign o_clip      = clip_q;
    assign o_overflow  = overflow_q;
    assign o_underflow = underflow_q;

endmodule

// File: tb/tb_ir_dry_wet_mixer.sv
// Directed, table-driven bench for ir_dry_wet_mixer; the ramp sequence runs when MIX_GAIN_RAMP_EN is defined.
module tb_ir_dry_wet_mixer;

    logic               clk = 1'b0;
    logic               rst = 1'b0;
    logic signed [15:0] dryData = '0;
    logic               dryValid = 1'b0;
    logic signed [15:0] wetData = '0;
    logic               wetValid = 1'b0;
    logic signed [15:0] dryGain = '0;
    logic signed [15:0] wetGain = '0;
    logic signed [15:0] oData;
    logic               oValid;
    logic               oClip;
    logic               oOverflow;
    logic               oUnderflow;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string name;
        int    dry;
        int    wet;
        int    dg;
        int    wg;
        int    expData;
        int    expClip;
    } vec_t;

    vec_t vecs[8];

    ir_dry_wet_mixer dut (
        .clk        (clk),
        .rst        (rst),
        .i_dry_data (dryData),
        .i_dry_valid(dryValid),
        .i_wet_data (wetData),
        .i_wet_valid(wetValid),
        .i_dry_gain (dryGain),
        .i_wet_gain (wetGain),
        .o_data     (oData),
        .o_valid    (oValid),
        .o_clip     (oClip),
        .o_overflow (oOverflow),
        .o_underflow(oUnderflow)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic doReset();
        rst      = 1'b0;
        dryValid = 1'b0;
        wetValid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checkOutput("reset o_valid", int'(oValid), 0);
        checkOutput("reset o_data", int'(oData), 0);
        checkOutput("reset o_clip", int'(oClip), 0);
        checkOutput("reset o_overflow", int'(oOverflow), 0);
        checkOutput("reset o_underflow", int'(oUnderflow), 0);
        checkOutput("reset count", int'(dut.alignFifo.count_o), 0);
        rst = 1'b1;
    endtask

    // One dry push, one wet a cycle later, then the 3-cycle latency window and the hold cycle.
    task automatic applyStimulus(input vec_t v);
        @(negedge clk);
        dryGain  = 16'(v.dg);
        wetGain  = 16'(v.wg);
        dryData  = 16'(v.dry);
        dryValid = 1'b1;
        @(negedge clk);
        dryValid = 1'b0;
        wetData  = 16'(v.wet);
        wetValid = 1'b1;
        @(negedge clk);
        wetValid = 1'b0;
        checkOutput({v.name, " valid@1"}, int'(oValid), 0);
        @(negedge clk);
        checkOutput({v.name, " valid@2"}, int'(oValid), 0);
        @(negedge clk);
        checkOutput({v.name, " valid@3"}, int'(oValid), 1);
        checkOutput({v.name, " data"}, int'(oData), v.expData);
        checkOutput({v.name, " clip"}, int'(oClip), v.expClip);
        @(negedge clk);
        checkOutput({v.name, " valid@4"}, int'(oValid), 0);
        checkOutput({v.name, " hold"}, int'(oData), v.expData);
        checkOutput({v.name, " clip@4"}, int'(oClip), 0);
    endtask

    initial begin
        vecs[0] = '{"unity dry",      1000,    500,  4096,     0,   1000, 0};
        vecs[1] = '{"half mix",       -800,    400,  2048,  2048,   -200, 0};
        vecs[2] = '{"trunc pos",         3,      0,  2048,  2048,      1, 0};
        vecs[3] = '{"sat pos",       30000,  10000,  4096,  4096,  32767, 1};
        vecs[4] = '{"sat neg",      -30000, -10000,  4096,  4096, -32768, 1};
        vecs[5] = '{"trunc neg",        -3,      0,  2048,  2048,     -2, 0};
        vecs[6] = '{"edge sum",      32767, -32768,  4096,  4096,     -1, 0};
        vecs[7] = '{"neg gain",       1000,      0, -4096,  4096,  -1000, 0};

        doReset();

`ifdef MIX_GAIN_RAMP_EN
        dryGain = 16'sd0;
        wetGain = 16'sd4096;
        wetData = 16'sd4096;
        for (int k = 0; k < 263; k++) begin
            @(negedge clk);
            if (k >= 3) begin
                int j;
                int expG;
                j    = k - 3;
                expG = ((j + 1) * 16 > 4096) ? 4096 : (j + 1) * 16;
                checkOutput($sformatf("ramp valid %0d", j), int'(oValid), 1);
                checkOutput($sformatf("ramp data %0d", j), int'(oData), expG);
            end
            wetValid = (k < 260);
        end
        wetValid = 1'b0;
`else
        foreach (vecs[i]) begin
            applyStimulus(vecs[i]);
        end
        checkOutput("table overflow", int'(oOverflow), 0);
        checkOutput("table underflow", int'(oUnderflow), 0);

        // Nine pushes into an eight-deep FIFO: the last is dropped, the first eight drain in order.
        doReset();
        dryGain = 16'sd4096;
        wetGain = 16'sd0;
        wetData = 16'sd0;
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            dryData  = 16'(100 + i);
            dryValid = 1'b1;
        end
        @(negedge clk);
        dryValid = 1'b0;
        checkOutput("ovf flag", int'(oOverflow), 1);
        checkOutput("ovf count", int'(dut.alignFifo.count_o), 8);
        checkOutput("ovf no underflow", int'(oUnderflow), 0);
        for (int k = 0; k < 11; k++) begin
            @(negedge clk);
            if (k >= 3) begin
                checkOutput($sformatf("ovf valid %0d", k - 3), int'(oValid), 1);
                checkOutput($sformatf("ovf data %0d", k - 3), int'(oData), 100 + k - 3);
            end
            wetValid = (k < 8);
        end
        checkOutput("drain count", int'(dut.alignFifo.count_o), 0);
        checkOutput("drain underflow", int'(oUnderflow), 0);

        // Wet into an empty FIFO with a simultaneous push: dry term is 0, push is kept.
        @(negedge clk);
        dryGain  = 16'sd4096;
        wetGain  = 16'sd4096;
        wetData  = 16'sd500;
        wetValid = 1'b1;
        dryData  = 16'sd777;
        dryValid = 1'b1;
        @(negedge clk);
        wetValid = 1'b0;
        dryValid = 1'b0;
        checkOutput("udf flag", int'(oUnderflow), 1);
        checkOutput("udf push stored", int'(dut.alignFifo.count_o), 1);
        @(negedge clk);
        @(negedge clk);
        checkOutput("udf valid", int'(oValid), 1);
        checkOutput("udf data", int'(oData), 500);
        @(negedge clk);
        wetData  = 16'sd0;
        wetValid = 1'b1;
        @(negedge clk);
        wetValid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checkOutput("stored valid", int'(oValid), 1);
        checkOutput("stored data", int'(oData), 777);
        checkOutput("udf sticky", int'(oUnderflow), 1);

        // Full FIFO with push and pop together: count holds, the pop returns the oldest entry.
        doReset();
        dryGain = 16'sd4096;
        wetGain = 16'sd0;
        wetData = 16'sd0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            dryData  = 16'(200 + i);
            dryValid = 1'b1;
        end
        @(negedge clk);
        dryValid = 1'b0;
        checkOutput("full count", int'(dut.alignFifo.count_o), 8);
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (k == 1) begin
                checkOutput("pushpop count", int'(dut.alignFifo.count_o), 8);
                checkOutput("pushpop overflow", int'(oOverflow), 0);
            end
            if (k >= 3) begin
                checkOutput($sformatf("pushpop valid %0d", k - 3), int'(oValid), 1);
                checkOutput($sformatf("pushpop data %0d", k - 3), int'(oData), 200 + k - 3);
            end
            dryData  = 16'sd208;
            dryValid = (k == 0);
            wetValid = (k < 9);
        end
`endif

        // Asynchronous reset while the pipeline is busy.
        doReset();
        dryGain = 16'sd4096;
        wetGain = 16'sd4096;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            wetData  = 16'(300 + k);
            wetValid = 1'b1;
        end
        @(negedge clk);
        wetValid = 1'b0;
        checkOutput("pre-reset valid", int'(oValid), 1);
        checkOutput("pre-reset underflow", int'(oUnderflow), 1);
        #1 rst = 1'b0;
        #1;
        checkOutput("async valid", int'(oValid), 0);
        checkOutput("async data", int'(oData), 0);
        checkOutput("async underflow", int'(oUnderflow), 0);
        checkOutput("async clip", int'(oClip), 0);
        @(negedge clk);
        rst = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            checkOutput($sformatf("no stale valid %0d", k), int'(oValid), 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
